mon_transmitter: RTL and testbench
==================================

// Module: mon_transmitter
// PURPOSE
//  Slave/transmitter end of the monInterface link. The master drives sel; this block drives data.
//  Two producer streams are each buffered in a FIFO. The channel chosen by sel presents its head word on data.
//  A word is popped when its sel window ends. Underrun windows are counted for debug.
// PARAMETERS
//  WIDTH      8      data word width (bits)
//  DEPTH      4      entries per channel FIFO; power of 2, >= 2
//  IDLE_WORD  8'h00  value driven on data when the selected FIFO is empty
//  CNT_W      8      width of the saturating underrun counter
// PORTS
//  clk        in   1               system clock, all logic on posedge
//  rst        in   1               synchronous, active-high reset
//  sel        in   1               channel select from master (0 = ch0, 1 = ch1)
//  data       out  WIDTH           registered word for the selected channel
//  in0_data   in   WIDTH           ch0 producer word
//  in0_valid  in   1               ch0 producer valid
//  in0_ready  out  1               ch0 FIFO not full (combinational from fill count)
//  in1_data   in   WIDTH           ch1 producer word
//  in1_valid  in   1               ch1 producer valid
//  in1_ready  out  1               ch1 FIFO not full
//  empty0     out  1               ch0 FIFO empty
//  empty1     out  1               ch1 FIFO empty
//  underrun   out  CNT_W           saturating count of windows that ended with nothing presented
// BEHAVIOUR
//  Reset (rst=1 at posedge)
//   - FIFO pointers and fill counts = 0; FIFO contents discarded; empty0 = empty1 = 1.
//   - data = IDLE_WORD; dv_q = 0; sel_q = 0; underrun = 0.
//   - Reset mid-operation drops all queued words; no pop or push occurs that cycle.
//  FIFOs
//   - Pointers are $clog2(DEPTH) bits and wrap naturally; fill counts are $clog2(DEPTH+1) bits.
//   - Push chN when inN_valid && inN_ready.
//   - inN_ready = (countN != DEPTH); a valid word offered while full is held by the producer, not lost.
//   - Push and pop on the same FIFO in the same cycle: count unchanged, both pointers advance.
//  Presentation (1-cycle latency)
//   - Every cycle: data <= countSel ? head[sel] : IDLE_WORD.
//   - Every cycle: dv_q <= (countSel != 0), where countSel is the fill count of FIFO[sel].
//   - sel_q <= sel every cycle.
//  Window end and pop
//   - Window end occurs in cycle t when sel != sel_q; the ending channel is c = sel_q.
//   - In cycle t, data still holds c's word, loaded from sel(t-1).
//   - If dv_q=1: pop FIFO[c] at the end of t, so the word was presented for at least one cycle.
//   - If dv_q=0: no pop; underrun increments, saturating at 2**CNT_W-1.
//   - A word pushed in the last cycle of its window is never presented and is never popped.
//   - sel may toggle every cycle; the rules above still hold.
//   - With sel held constant there is no window end: the head stays presented and nothing pops.
//  Data-path load and pop in cycle t target different FIFOs (sel vs sel_q), so there is no conflict.
// TESTING
//  1 Reset: assert rst for 2 cycles with producers active.
//    -> data=8'h00, empty0=empty1=1, underrun=0, in0_ready=in1_ready=1.
//  2 Basic: push 8'hA1,8'hA2 on ch0 and 8'hB1 on ch1; then drive sel=cmpt[1] (2-cycle windows).
//    -> data sequence A1,A1,B1,B1,A2,A2, then IDLE; underrun increments from the first empty window.
//  3 Full: push 5 words on ch0 with sel=1 held.
//    -> in0_ready=0 after the 4th push; 5th word held; accepted one cycle after the first ch0 pop.
//  4 Late push: ch1 empty; push 8'h55 in the last cycle of a ch1 window.
//    -> not popped; underrun +1; 8'h55 appears in the next ch1 window.
//  5 Saturation: CNT_W=2, sel toggling each cycle, both FIFOs empty.
//    -> underrun counts 1,2,3 and stays at 3.
//  6 Mid-op reset: queue 3 words per channel, pulse rst for 1 cycle mid-window.
//    -> FIFOs empty, data=IDLE_WORD next cycle, underrun=0, no stale word ever output.

Source files
------------

// File: rtl/mon_transmitter.sv
// Transmitter end of the monInterface link: two buffered producer
// channels, sel-driven presentation, pop on window end, underrun count.
module mon_transmitter #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] IDLE_WORD = '0,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  output logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic             empty0,
  output logic             empty1,
  output logic [CNT_W-1:0] underrun
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CNT_W-1:0] UMAX = '1;

  logic [WIDTH-1:0] mem0 [DEPTH];
  logic [WIDTH-1:0] mem1 [DEPTH];

  logic [PW-1:0]    wr0_q, wr0_d, rd0_q, rd0_d;
  logic [PW-1:0]    wr1_q, wr1_d, rd1_q, rd1_d;
  logic [CW-1:0]    cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dv_q, dv_d;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] unr_q, unr_d;

  logic push0, push1, pop0, pop1, win_end;
  logic [CW-1:0]    cnt_sel;
  logic [WIDTH-1:0] head_sel;

  assign in0_ready = (cnt0_q != FULL);
  assign in1_ready = (cnt1_q != FULL);
  assign empty0    = (cnt0_q == '0);
  assign empty1    = (cnt1_q == '0);
  assign data      = data_q;
  assign underrun  = unr_q;

  assign push0   = in0_valid && in0_ready;
  assign push1   = in1_valid && in1_ready;
  // The window of sel_q closes; its word was shown only if dv_q.
  assign win_end = (sel != sel_q);
  assign pop0    = win_end && dv_q && !sel_q;
  assign pop1    = win_end && dv_q && sel_q;

  assign cnt_sel  = sel ? cnt1_q : cnt0_q;
  assign head_sel = sel ? mem1[rd1_q] : mem0[rd0_q];

  // Next-state for pointers, fill counts, presentation and counter.
  always_comb begin
    wr0_d  = wr0_q;
    rd0_d  = rd0_q;
    cnt0_d = cnt0_q;
    wr1_d  = wr1_q;
    rd1_d  = rd1_q;
    cnt1_d = cnt1_q;
    unr_d  = unr_q;
    if (push0) wr0_d = wr0_q + 1'b1;
    if (pop0)  rd0_d = rd0_q + 1'b1;
    if (push0 && !pop0) cnt0_d = cnt0_q + 1'b1;
    if (!push0 && pop0) cnt0_d = cnt0_q - 1'b1;
    if (push1) wr1_d = wr1_q + 1'b1;
    if (pop1)  rd1_d = rd1_q + 1'b1;
    if (push1 && !pop1) cnt1_d = cnt1_q + 1'b1;
    if (!push1 && pop1) cnt1_d = cnt1_q - 1'b1;
    if (win_end && !dv_q && unr_q != UMAX)
      unr_d = unr_q + 1'b1;
    data_d = (cnt_sel != '0) ? head_sel : IDLE_WORD;
    dv_d   = (cnt_sel != '0);
    sel_d  = sel;
  end

  // Control and presentation registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr0_q  <= '0;
      rd0_q  <= '0;
      cnt0_q <= '0;
      wr1_q  <= '0;
      rd1_q  <= '0;
      cnt1_q <= '0;
      data_q <= IDLE_WORD;
      dv_q   <= 1'b0;
      sel_q  <= 1'b0;
      unr_q  <= '0;
    end else begin
      wr0_q  <= wr0_d;
      rd0_q  <= rd0_d;
      cnt0_q <= cnt0_d;
      wr1_q  <= wr1_d;
      rd1_q  <= rd1_d;
      cnt1_q <= cnt1_d;
      data_q <= data_d;
      dv_q   <= dv_d;
      sel_q  <= sel_d;
      unr_q  <= unr_d;
    end
  end

  // FIFO storage; contents are left stale on reset, counts gate them.
  always_ff @(posedge clk) begin
    if (!rst && push0) mem0[wr0_q] <= in0_data;
    if (!rst && push1) mem1[wr1_q] <= in1_data;
  end

endmodule

// File: tb/tb_mon_transmitter.sv
// Scoreboard bench for mon_transmitter: directed cycles push hand-derived
// expectations, a negedge monitor pops and compares every cycle.
module tb_mon_transmitter;

  logic       clk = 1'b0;
  logic       rst, sel;
  logic [7:0] data;
  logic [7:0] in0_data, in1_data;
  logic       in0_valid, in1_valid, in0_ready, in1_ready;
  logic       empty0, empty1;
  logic [1:0] underrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      nm;
    logic [7:0] d;
    logic [1:0] u;
    logic       e0, e1, r0, r1;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  mon_transmitter #(
    .WIDTH(8), .DEPTH(4), .IDLE_WORD(8'h00), .CNT_W(2)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .data(data),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .empty0(empty0), .empty1(empty1), .underrun(underrun)
  );

  // Monitor: one expectation per clock, compared away from the edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [13:0] act, req;
      e = exp_q.pop_front();
      act = {data, underrun, empty0, empty1, in0_ready, in1_ready};
      req = {e.d, e.u, e.e0, e.e1, e.r0, e.r1};
      checks++;
      if (act !== req) begin
        errors++;
        $display("FAIL %s: got data=%h unr=%0d e0=%b e1=%b r0=%b r1=%b, want data=%h unr=%0d e0=%b e1=%b r0=%b r1=%b",
                 e.nm, data, underrun, empty0, empty1, in0_ready, in1_ready,
                 e.d, e.u, e.e0, e.e1, e.r0, e.r1);
      end
    end
  end

  task automatic step(
    input string nm, input bit r, input bit s,
    input bit v0, input logic [7:0] d0,
    input bit v1, input logic [7:0] d1,
    input logic [7:0] ed, input logic [1:0] eu,
    input bit ee0, input bit ee1, input bit er0, input bit er1);
    exp_t e;
    rst = r; sel = s;
    in0_valid = v0; in0_data = d0;
    in1_valid = v1; in1_data = d1;
    @(posedge clk);
    e.nm = nm; e.d = ed; e.u = eu;
    e.e0 = ee0; e.e1 = ee1; e.r0 = er0; e.r1 = er1;
    exp_q.push_back(e);
    #1;
  endtask

  initial begin
    // 1 reset with producers active
    step("rst_a", 1,0, 1,8'h11, 1,8'h22, 8'h00,0, 1,1,1,1);
    step("rst_b", 1,0, 1,8'h11, 1,8'h22, 8'h00,0, 1,1,1,1);
    // 2 basic
    step("bas_a", 0,0, 1,8'hA1, 1,8'hB1, 8'h00,0, 0,0,1,1);
    step("bas_b", 0,0, 1,8'hA2, 0,8'h00, 8'hA1,0, 0,0,1,1);
    step("bas_c", 0,1, 0,8'h00, 0,8'h00, 8'hB1,0, 0,0,1,1);
    step("bas_d", 0,1, 0,8'h00, 0,8'h00, 8'hB1,0, 0,0,1,1);
    step("bas_e", 0,0, 0,8'h00, 0,8'h00, 8'hA2,0, 0,1,1,1);
    step("bas_f", 0,0, 0,8'h00, 0,8'h00, 8'hA2,0, 0,1,1,1);
    step("bas_g", 0,1, 0,8'h00, 0,8'h00, 8'h00,0, 1,1,1,1);
    step("bas_h", 0,1, 0,8'h00, 0,8'h00, 8'h00,0, 1,1,1,1);
    step("bas_i", 0,0, 0,8'h00, 0,8'h00, 8'h00,1, 1,1,1,1);
    step("bas_j", 0,0, 0,8'h00, 0,8'h00, 8'h00,1, 1,1,1,1);
    step("bas_k", 0,1, 0,8'h00, 0,8'h00, 8'h00,2, 1,1,1,1);
    step("bas_l", 0,1, 0,8'h00, 0,8'h00, 8'h00,2, 1,1,1,1);
    step("bas_m", 0,0, 0,8'h00, 0,8'h00, 8'h00,3, 1,1,1,1);
    // 3 full FIFO, held fifth word
    step("ful_r", 1,1, 0,8'h00, 0,8'h00, 8'h00,0, 1,1,1,1);
    step("ful_1", 0,1, 1,8'hC1, 0,8'h00, 8'h00,1, 0,1,1,1);
    step("ful_2", 0,1, 1,8'hC2, 0,8'h00, 8'h00,1, 0,1,1,1);
    step("ful_3", 0,1, 1,8'hC3, 0,8'h00, 8'h00,1, 0,1,1,1);
    step("ful_4", 0,1, 1,8'hC4, 0,8'h00, 8'h00,1, 0,1,0,1);
    step("ful_5", 0,1, 1,8'hC5, 0,8'h00, 8'h00,1, 0,1,0,1);
    step("ful_6", 0,0, 1,8'hC5, 0,8'h00, 8'hC1,2, 0,1,0,1);
    step("ful_7", 0,1, 1,8'hC5, 0,8'h00, 8'h00,2, 0,1,1,1);
    step("ful_8", 0,1, 1,8'hC5, 0,8'h00, 8'h00,2, 0,1,0,1);
    step("ful_9", 0,0, 0,8'h00, 0,8'h00, 8'hC2,3, 0,1,0,1);
    step("ful_10",0,1, 0,8'h00, 0,8'h00, 8'h00,3, 0,1,1,1);
    step("ful_11",0,0, 0,8'h00, 0,8'h00, 8'hC3,3, 0,1,1,1);
    step("ful_12",0,1, 0,8'h00, 0,8'h00, 8'h00,3, 0,1,1,1);
    step("ful_13",0,0, 0,8'h00, 0,8'h00, 8'hC4,3, 0,1,1,1);
    step("ful_14",0,1, 0,8'h00, 0,8'h00, 8'h00,3, 0,1,1,1);
    step("ful_15",0,0, 0,8'h00, 0,8'h00, 8'hC5,3, 0,1,1,1);
    step("ful_16",0,1, 0,8'h00, 0,8'h00, 8'h00,3, 1,1,1,1);
    // 4 late push in last cycle of a ch1 window
    step("lat_r", 1,0, 0,8'h00, 0,8'h00, 8'h00,0, 1,1,1,1);
    step("lat_w1",0,1, 0,8'h00, 0,8'h00, 8'h00,1, 1,1,1,1);
    step("lat_w2",0,1, 0,8'h00, 1,8'h55, 8'h00,1, 1,0,1,1);
    step("lat_x1",0,0, 0,8'h00, 0,8'h00, 8'h00,2, 1,0,1,1);
    step("lat_x2",0,0, 0,8'h00, 0,8'h00, 8'h00,2, 1,0,1,1);
    step("lat_y1",0,1, 0,8'h00, 0,8'h00, 8'h55,3, 1,0,1,1);
    step("lat_y2",0,1, 0,8'h00, 0,8'h00, 8'h55,3, 1,0,1,1);
    step("lat_z1",0,0, 0,8'h00, 0,8'h00, 8'h00,3, 1,1,1,1);
    // 5 underrun saturation
    step("sat_r", 1,0, 0,8'h00, 0,8'h00, 8'h00,0, 1,1,1,1);
    step("sat_1", 0,1, 0,8'h00, 0,8'h00, 8'h00,1, 1,1,1,1);
    step("sat_2", 0,0, 0,8'h00, 0,8'h00, 8'h00,2, 1,1,1,1);
    step("sat_3", 0,1, 0,8'h00, 0,8'h00, 8'h00,3, 1,1,1,1);
    step("sat_4", 0,0, 0,8'h00, 0,8'h00, 8'h00,3, 1,1,1,1);
    step("sat_5", 0,1, 0,8'h00, 0,8'h00, 8'h00,3, 1,1,1,1);
    // 6 mid-operation reset
    step("mid_r", 1,0, 0,8'h00, 0,8'h00, 8'h00,0, 1,1,1,1);
    step("mid_q1",0,0, 1,8'hD1, 1,8'hE1, 8'h00,0, 0,0,1,1);
    step("mid_q2",0,0, 1,8'hD2, 1,8'hE2, 8'hD1,0, 0,0,1,1);
    step("mid_q3",0,0, 1,8'hD3, 1,8'hE3, 8'hD1,0, 0,0,1,1);
    step("mid_q4",0,1, 0,8'h00, 0,8'h00, 8'hE1,0, 0,0,1,1);
    step("mid_q5",1,1, 1,8'hF0, 1,8'hF1, 8'h00,0, 1,1,1,1);
    step("mid_q6",0,1, 0,8'h00, 0,8'h00, 8'h00,1, 1,1,1,1);
    step("mid_q7",0,0, 0,8'h00, 0,8'h00, 8'h00,2, 1,1,1,1);
    step("mid_q8",0,1, 0,8'h00, 0,8'h00, 8'h00,3, 1,1,1,1);
    // drain the scoreboard, bounded
    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
